// File: rtl/ffapuf_mchain.sv
// N_CHAINS flip-flop arbiter PUF chains, each evaluated N_EVAL times and majority-voted per bit.
// Latency: done N_EVAL*(SETTLE_CYC+3)+1 cycles after start is accepted; start is ignored while busy.
module ffapuf_mchain #(
  parameter int N_STAGES   = 8,
  parameter int N_CHAINS   = 4,
  parameter int N_EVAL     = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic [N_CHAINS*N_STAGES-1:0] challenge,
  output logic                         busy,
  output logic                         done,
  output logic [N_CHAINS-1:0]          response,
  output logic [N_CHAINS-1:0]          unstable
);
  localparam int EW = $clog2(N_EVAL + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [EW-1:0] HALF  = EW'(N_EVAL / 2);
  localparam logic [EW-1:0] NEV   = EW'(N_EVAL);
  localparam logic [EW-1:0] LAST  = EW'(N_EVAL - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, DONE} state_t;

  state_t                       state, state_nx;
  logic [N_CHAINS*N_STAGES-1:0] challenge_q;
  logic [EW-1:0]                eval_cnt;
  logic [SW-1:0]                settle_cnt;
  logic [EW-1:0]                vote     [N_CHAINS];
  logic [EW-1:0]                vote_sum [N_CHAINS];
  logic [N_CHAINS-1:0]          resp_nx, unst_nx;
  logic [N_CHAINS-1:0]          arb_bit;
  logic                         chain_clr, launch;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    chain_clr = 1'b0;
    launch    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = CLEAR;
      end
      CLEAR: begin
        chain_clr = 1'b1;
        state_nx  = LAUNCH;
      end
      LAUNCH: begin
        launch   = 1'b1;
        state_nx = SETTLE;
      end
      SETTLE: if (settle_cnt == SLAST) state_nx = SAMPLE;
      SAMPLE: state_nx = (eval_cnt == LAST) ? DONE : CLEAR;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Final votes include the bit being sampled so the result is valid in the DONE cycle.
  always_comb begin
    for (int i = 0; i < N_CHAINS; i++) begin
      vote_sum[i] = vote[i] + EW'(arb_bit[i]);
      resp_nx[i]  = (vote_sum[i] > HALF);
      unst_nx[i]  = (vote_sum[i] != '0) && (vote_sum[i] != NEV);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      challenge_q <= '0;
      eval_cnt    <= '0;
      settle_cnt  <= '0;
      response    <= '0;
      unstable    <= '0;
      for (int i = 0; i < N_CHAINS; i++) vote[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            challenge_q <= challenge;
            eval_cnt    <= '0;
            for (int i = 0; i < N_CHAINS; i++) vote[i] <= '0;
          end
        end
        LAUNCH: settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + SW'(1);
        SAMPLE: begin
          eval_cnt <= eval_cnt + EW'(1);
          for (int i = 0; i < N_CHAINS; i++) vote[i] <= vote_sum[i];
          if (eval_cnt == LAST) begin
            response <= resp_nx;
            unstable <= unst_nx;
          end
        end
        default: ;
      endcase
    end
  end

  // Deeper stages are self-timed by the race, so they only observe chain_clr on their own edges.
  for (genvar i = 0; i < N_CHAINS; i++) begin : g_chain
    logic [N_STAGES-1:0] mux_o;
    (* dont_touch = "true" *) logic arb_q;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      (* dont_touch = "true" *) logic ff_a;
      (* dont_touch = "true" *) logic ff_b;
      logic stg_clk, adv;

      if (k == 0) begin : g_src
        assign stg_clk = clk;
        assign adv     = launch;
      end else begin : g_src
        assign stg_clk = mux_o[k-1];
        assign adv     = 1'b1;
      end

      always_ff @(posedge stg_clk or negedge clr) begin
        if (!clr) begin
          ff_a <= 1'b0;
          ff_b <= 1'b0;
        end else if (chain_clr) begin
          ff_a <= 1'b0;
          ff_b <= 1'b0;
        end else if (adv) begin
          ff_a <= ~ff_a;
          ff_b <= ff_a;
        end
      end

      assign mux_o[k] = challenge_q[i*N_STAGES + k] ? ff_b : ff_a;
    end

    always_ff @(posedge g_stage[N_STAGES-1].ff_b or negedge clr) begin
      if (!clr)           arb_q <= 1'b0;
      else if (chain_clr) arb_q <= 1'b0;
      else                arb_q <= g_stage[N_STAGES-1].ff_a;
    end

    assign arb_bit[i] = arb_q;
  end

endmodule

// File: tb/tb_ffapuf_mchain.sv
// Directed bench for ffapuf_mchain: arbiter bits are forced per evaluation, votes checked against hand-computed tables.
module tb_ffapuf_mchain;
  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] challenge;
  logic        busy, done;
  logic [3:0]  response, unstable;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  arb_v;
  logic [3:0]  prev_resp, prev_unst;

  typedef struct {
    logic [31:0]     chal;
    logic [4:0][3:0] arb;   // arb[e] is the forced arbiter value of evaluation e
    logic [3:0]      resp;
    logic [3:0]      unst;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  ffapuf_mchain dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .challenge (challenge),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .unstable  (unstable)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_arb(input logic [3:0] v);
    arb_v = v;
    force dut.arb_bit = arb_v;
  endtask

  // One request; cycle c is the c-th cycle after the accept edge, SAMPLE of eval e is c = 7*(e+1).
  task automatic run(input string tag, input logic [31:0] chal, input logic [4:0][3:0] arb,
                     input bit noisy, input int abort_at,
                     input logic [3:0] exp_r, input logic [3:0] exp_u);
    int lat;
    int bcnt;
    lat  = -1;
    bcnt = 0;
    @(negedge clk);
    challenge = chal;
    start     = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (noisy && c >= 3 && c <= 30 && (c % 5) == 0) begin
        start     = 1'b1;
        challenge = $urandom;
      end
      if ((c % 7) == 0 && c <= 35) set_arb(arb[c/7-1]);
      if (c == 2) begin
        check({tag, " hold response"}, {28'd0, response}, {28'd0, prev_resp});
        check({tag, " hold unstable"}, {28'd0, unstable}, {28'd0, prev_unst});
      end
      if (c == abort_at) begin
        clr = 1'b0;
        #1;
        check({tag, " rst busy"}, {31'd0, busy}, 32'd0);
        check({tag, " rst done"}, {31'd0, done}, 32'd0);
        check({tag, " rst response"}, {28'd0, response}, 32'd0);
        check({tag, " rst unstable"}, {28'd0, unstable}, 32'd0);
        @(negedge clk);
        check({tag, " rst stays idle"}, {31'd0, busy}, 32'd0);
        clr       = 1'b1;
        prev_resp = 4'd0;
        prev_unst = 4'd0;
        return;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, lat, 32'd36);
    check({tag, " busy cycles"}, bcnt, 32'd36);
    check({tag, " response"}, {28'd0, response}, {28'd0, exp_r});
    check({tag, " unstable"}, {28'd0, unstable}, {28'd0, exp_u});
    check({tag, " challenge_q"}, dut.challenge_q, chal);
    @(negedge clk);
    check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    check({tag, " idle after done"}, {31'd0, busy}, 32'd0);
    prev_resp = exp_r;
    prev_unst = exp_u;
  endtask

  initial begin
    int d1, d2;
    int aborts [6];

    vecs[0] = '{32'hA5C3_0F96, {5{4'b1010}}, 4'b1010, 4'b0000};
    vecs[1] = '{32'h0F0F_1234, {4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001}, 4'b0001, 4'b0001};
    vecs[2] = '{32'h8421_FEDC, {4'b0011, 4'b1010, 4'b1111, 4'b1010, 4'b1010}, 4'b1010, 4'b1101};
    vecs[3] = '{32'h0000_0000, {5{4'b0000}}, 4'b0000, 4'b0000};
    vecs[4] = '{32'hFFFF_FFFF, {5{4'b1111}}, 4'b1111, 4'b0000};
    vecs[5] = '{32'h1357_9BDF, {4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111}, 4'b1111, 4'b1111};
    vecs[6] = '{32'h2468_ACE0, {4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000}, 4'b0000, 4'b1111};
    vecs[7] = '{32'hDEAD_BEEF, {4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1011}, 4'b1010, 4'b0011};
    aborts  = '{1, 2, 4, 7, 19, 36};

    clr       = 1'b0;
    start     = 1'b0;
    challenge = 32'd0;
    prev_resp = 4'd0;
    prev_unst = 4'd0;
    set_arb(4'd0);
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset response", {28'd0, response}, 32'd0);
    check("reset unstable", {28'd0, unstable}, 32'd0);
    clr = 1'b1;

    for (int i = 0; i < 8; i++)
      run($sformatf("vec%0d", i), vecs[i].chal, vecs[i].arb, 1'b0, 0, vecs[i].resp, vecs[i].unst);

    run("busy noise", 32'h1234_5678, {5{4'b0110}}, 1'b1, 0, 4'b0110, 4'b0000);

    // Each abort is preceded by a full run so the cleared outputs were nonzero beforehand.
    for (int a = 0; a < 6; a++) begin
      run($sformatf("pre abort%0d", a), 32'hFFFF_0000, {5{4'b1111}}, 1'b0, 0, 4'b1111, 4'b0000);
      run($sformatf("abort at %0d", aborts[a]), 32'hFFFF_0000, {5{4'b1111}}, 1'b0, aborts[a], 4'b0000, 4'b0000);
    end
    run("fresh after abort", 32'h00FF_00FF, {5{4'b1111}}, 1'b0, 0, 4'b1111, 4'b0000);

    set_arb(4'b0110);
    @(negedge clk);
    challenge = 32'hC0DE_1234;
    start     = 1'b1;
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (d1 != 0 && c == d1 + 1) check("held idle gap", {31'd0, busy}, 32'd0);
      if (d1 != 0 && c == d1 + 2) check("held re-accept", {31'd0, busy}, 32'd1);
      if (done) begin
        check("held response", {28'd0, response}, 32'h6);
        check("held unstable", {28'd0, unstable}, 32'd0);
        if (d1 == 0) begin
          d1 = c;
        end else begin
          d2    = c;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("held first done", d1, 32'd36);
    check("held done spacing", d2 - d1, 32'd37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
